gpu_regfile_param: RTL
======================

Name: gpu_regfile_param

Overview:
- Per-thread general-purpose register file for the GPU compute core; one instance per thread lane.
- Successor to the fixed 16x8 register file: parametrised in width and depth, with reads and writes gated by `core_state`.
- Adds read-only special registers (block id, block dim, thread id), same-cycle write-to-read bypass, a read-valid strobe and a sticky illegal-write flag.
- Feeds the ALU/LSU operand inputs. Write data arrives from the core's ALU/LSU/immediate mux.

Parameters:
- DATA_WIDTH, 8, register and operand width in bits.
- NUM_REGS, 16, total registers; minimum 4, power of two.
- ADDR_WIDTH, $clog2(NUM_REGS), register address width.
- THREAD_ID, 0, constant returned by register NUM_REGS-1; truncated to DATA_WIDTH.
- STATE_READ, 3'b011, `core_state` code in which operands are latched.
- STATE_UPDATE, 3'b110, `core_state` code in which writeback is permitted.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  thread lane active; when low the block ignores reads and writes and holds all state.
- core_state  in  3  core pipeline state.
- block_id  in  DATA_WIDTH  current block index, sampled live.
- block_dim  in  DATA_WIDTH  threads per block, sampled live.
- reg_write_enable  in  1  writeback request.
- rs_addr  in  ADDR_WIDTH  source operand 1 address.
- rt_addr  in  ADDR_WIDTH  source operand 2 address.
- rd_addr  in  ADDR_WIDTH  destination address.
- data_write  in  DATA_WIDTH  writeback data.
- rs  out  DATA_WIDTH  registered operand 1.
- rt  out  DATA_WIDTH  registered operand 2.
- read_valid  out  1  one-cycle pulse: rs/rt updated on this edge.
- ro_write_err  out  1  sticky: a write to a read-only register was attempted.

Behaviour:
- Register map:
  - R0..R(NUM_REGS-4) are writable.
  - R(NUM_REGS-3) = block_id, R(NUM_REGS-2) = block_dim, R(NUM_REGS-1) = THREAD_ID. All three are read-only and combinational from their sources.
- Reset (reset low, asynchronous):
  - All writable registers cleared to 0.
  - rs, rt cleared to 0; read_valid = 0; ro_write_err = 0.
  - Reset asserted mid-operation aborts any pending read or write. No partial update survives.
- Read (enable=1, core_state==STATE_READ):
  - On the rising edge, rs <= value(rs_addr) and rt <= value(rt_addr).
  - read_valid = 1 for exactly that following cycle.
  - Latency is 1 cycle. rs/rt hold their value in every other cycle.
  - read_valid stays high on consecutive edges if STATE_READ persists.
- Write (enable=1, reg_write_enable=1, core_state==STATE_UPDATE):
  - On the rising edge, the writable register at rd_addr <= data_write.
  - reg_write_enable in any other state is ignored; no error is flagged.
- Read-only target:
  - A write request to rd_addr >= NUM_REGS-3 under STATE_UPDATE is dropped.
  - ro_write_err is set to 1 and held until reset.
- Bypass:
  - A write and a read never share a state, so the same-edge hazard is impossible by state encoding.
  - The bypass covers the registered-write path: a read in the cycle immediately after a write to the same address returns the new data, with no stale read.
- enable = 0: no register, rs/rt, or flag changes, and read_valid = 0.
- Addresses are full-range by construction, so there is no out-of-range case. rs_addr == rt_addr returns the same value on both ports.
- There is no arithmetic; data is passed unmodified at DATA_WIDTH.

Test Plan:
- Reset then read: assert reset low, release, STATE_READ with rs_addr=0, rt_addr=5 -> rs=0, rt=0, read_valid pulses 1 cycle after.
- Writeback then read: STATE_UPDATE, rd_addr=3, data_write=8'hA5, reg_write_enable=1; next cycle STATE_READ rs_addr=3 -> rs=8'hA5 one edge later.
- Special registers: block_id=8'h07, block_dim=8'h04, THREAD_ID=2; read R13 and R15 -> rs=8'h07, rt=8'h02; then read R14 -> 8'h04.
- Illegal write: STATE_UPDATE, rd_addr=15, data_write=8'hFF -> R15 still reads 2, ro_write_err=1 and stays 1 until reset.
- Gating: reg_write_enable=1 with core_state=3'b011 and rd_addr=1 -> R1 unchanged. Repeat with enable=0 in STATE_UPDATE -> R1 unchanged, read_valid=0.
- Mid-operation reset: write 8'h3C to R2, assert reset low between edges during STATE_READ -> rs=0 immediately, R2 reads 0 after release.

Source files
------------

// File: rtl/gpu_regfile_param.sv
// gpu_regfile_param: per-thread register file for one GPU thread lane.
// R0..R(NUM_REGS-4) are writable. The top three addresses are read-only
// views of block_id, block_dim and the THREAD_ID constant. Operands are
// latched in STATE_READ and writeback happens in STATE_UPDATE.
//
// Operand strobe: read_valid is a plain valid with no ready. It is high for
// exactly the cycle after an edge that latched rs/rt. The consumer must take
// rs/rt while read_valid is high; the value holds afterwards until the next
// read edge. Back-to-back read edges keep read_valid high continuously.
module gpu_regfile_param #(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_REGS     = 16,
    parameter int ADDR_WIDTH   = $clog2(NUM_REGS),
    parameter int THREAD_ID    = 0,
    parameter logic [2:0] STATE_READ   = 3'b011,
    parameter logic [2:0] STATE_UPDATE = 3'b110
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [2:0]            core_state,
    input  logic [DATA_WIDTH-1:0] block_id,
    input  logic [DATA_WIDTH-1:0] block_dim,
    input  logic                  reg_write_enable,
    input  logic [ADDR_WIDTH-1:0] rs_addr,
    input  logic [ADDR_WIDTH-1:0] rt_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] data_write,
    output logic [DATA_WIDTH-1:0] rs,
    output logic [DATA_WIDTH-1:0] rt,
    output logic                  read_valid,
    output logic                  ro_write_err
);

    // Addresses of the read-only special registers.
    localparam logic [ADDR_WIDTH-1:0] BID_ADDR  = ADDR_WIDTH'(NUM_REGS - 3);
    localparam logic [ADDR_WIDTH-1:0] BDIM_ADDR = ADDR_WIDTH'(NUM_REGS - 2);
    localparam logic [ADDR_WIDTH-1:0] TID_ADDR  = ADDR_WIDTH'(NUM_REGS - 1);
    localparam logic [DATA_WIDTH-1:0] TID_VALUE = DATA_WIDTH'(THREAD_ID);

    // Storage is sized to the full address space so any address indexes it
    // directly. The three top entries are never written and stay at zero.
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    logic                  read_fire;
    logic                  write_req;
    logic                  write_ok;
    logic                  write_ro;
    logic [DATA_WIDTH-1:0] rs_val;
    logic [DATA_WIDTH-1:0] rt_val;

    // Decode read and write requests from the gating inputs.
    always_comb begin
        read_fire = enable && (core_state == STATE_READ);
        write_req = enable && reg_write_enable && (core_state == STATE_UPDATE);
        write_ok  = write_req && (rd_addr < BID_ADDR);
        write_ro  = write_req && (rd_addr >= BID_ADDR);
    end

    // Operand 1 mux: special registers are live, writable ones come from
    // storage, and a same-edge write to the same address is forwarded. That
    // forwarding only matters if STATE_READ and STATE_UPDATE are configured
    // to the same code; a write one cycle earlier is already in storage.
    always_comb begin
        rs_val = regs[rs_addr];
        if (rs_addr == BID_ADDR) begin
            rs_val = block_id;
        end else if (rs_addr == BDIM_ADDR) begin
            rs_val = block_dim;
        end else if (rs_addr == TID_ADDR) begin
            rs_val = TID_VALUE;
        end else if (write_ok && (rd_addr == rs_addr)) begin
            rs_val = data_write;
        end
    end

    // Operand 2 mux, same structure as operand 1.
    always_comb begin
        rt_val = regs[rt_addr];
        if (rt_addr == BID_ADDR) begin
            rt_val = block_id;
        end else if (rt_addr == BDIM_ADDR) begin
            rt_val = block_dim;
        end else if (rt_addr == TID_ADDR) begin
            rt_val = TID_VALUE;
        end else if (write_ok && (rd_addr == rt_addr)) begin
            rt_val = data_write;
        end
    end

    // Writeback into the writable registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_ok) begin
            regs[rd_addr] <= data_write;
        end
    end

    // Operand latches and the read-valid strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rs         <= '0;
            rt         <= '0;
            read_valid <= 1'b0;
        end else begin
            read_valid <= read_fire;
            if (read_fire) begin
                rs <= rs_val;
                rt <= rt_val;
            end
        end
    end

    // Sticky flag for writes aimed at a read-only register; cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ro_write_err <= 1'b0;
        end else if (write_ro) begin
            ro_write_err <= 1'b1;
        end
    end

endmodule
